// File: rtl/aes_pkg.sv
// Shared AES types, constants and GF(2^8) helpers used by the key schedule and cipher core.
package aes_pkg;

  typedef logic [31:0]  word_t;
  typedef logic [127:0] rkey_t;

  localparam int unsigned AES_NK    = 4;
  localparam logic [7:0]  RCON_INIT = 8'h01;

  typedef enum logic [1:0] {StIdle, StExpand, StDone} ke_state_e;

  // Multiply by x in GF(2^8) modulo the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box; shared between the key schedule and SubBytes.
module aes_sbox (
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);

  localparam logic [0:255][7:0] SboxTbl = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign out_o = SboxTbl[in_i];

endmodule

// File: rtl/key_expander.sv
// AES-128 key schedule: one round key per clock into an 11-entry register file with a
// combinational random-access read port.
module key_expander
  import aes_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic [127:0] key,
  input  logic         key_received,
  input  logic [3:0]   round_sel,
  output logic [127:0] round_key,
  output logic         busy,
  output logic         keys_ready,
  output logic         expand_done
);

  localparam int unsigned CntW = $clog2(NUM_ROUNDS + 1);

  ke_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [7:0]      rcon_q, rcon_d;
  logic            kr_q;
  logic            done_q, done_d;
  rkey_t           rk_q [NUM_ROUNDS+1];

  logic            start;
  logic            last_round;
  logic [CntW-1:0] prev_idx;
  rkey_t           prev;
  word_t           rot, sub, t, w0, w1, w2, w3;
  logic            rk_we;
  logic [CntW-1:0] rk_widx;
  rkey_t           rk_wdata;

  assign start      = key_received & ~kr_q;
  assign last_round = (cnt_q == CntW'(NUM_ROUNDS));

  // Round computation on the previous entry.
  assign prev_idx = cnt_q - CntW'(1);
  assign prev     = rk_q[prev_idx];
  assign rot      = {prev[23:0], prev[31:24]};

  for (genvar i = 0; i < AES_NK; i++) begin : g_subword
    aes_sbox u_sbox (
      .in_i  (rot[8*i +: 8]),
      .out_o (sub[8*i +: 8])
    );
  end

  assign t  = sub ^ {rcon_q, 24'h0};
  assign w0 = prev[127:96] ^ t;
  assign w1 = prev[95:64]  ^ w0;
  assign w2 = prev[63:32]  ^ w1;
  assign w3 = prev[31:0]   ^ w2;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rcon_q  <= RCON_INIT;
      kr_q    <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i <= int'(NUM_ROUNDS); i++) begin
        rk_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rcon_q  <= rcon_d;
      kr_q    <= key_received;
      done_q  <= done_d;
      if (rk_we) begin
        rk_q[rk_widx] <= rk_wdata;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) state_d = StExpand;
      end
      StExpand: begin
        if (start)           state_d = StExpand;
        else if (last_round) state_d = StDone;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cnt_d    = cnt_q;
    rcon_d   = rcon_q;
    rk_we    = 1'b0;
    rk_widx  = cnt_q;
    rk_wdata = {w0, w1, w2, w3};
    done_d   = 1'b0;
    if (start) begin
      // A new key always wins, including mid-expansion aborts.
      rk_we    = 1'b1;
      rk_widx  = '0;
      rk_wdata = key;
      cnt_d    = CntW'(1);
      rcon_d   = RCON_INIT;
    end else if (state_q == StExpand) begin
      rk_we  = 1'b1;
      cnt_d  = cnt_q + CntW'(1);
      rcon_d = xtime(rcon_q);
      done_d = last_round;
    end
  end

  always_comb begin
    busy        = (state_q == StExpand);
    keys_ready  = (state_q == StDone);
    expand_done = done_q;
  end

  assign round_key = (32'(round_sel) <= NUM_ROUNDS) ? rk_q[round_sel] : '0;

endmodule
